speck_mmo_hash: RTL and testbench

- Parametrised iterative Speck-2N/2N compression core (two-word key schedule, m=2) wrapped in Matyas-Meyer-Oseas chaining: H_i = E_{H_(i-1)}(M_i) XOR M_i.
- Successor to the fixed 64-bit Speck hash datapath. It generalises word width, rotations and round count, and adds an on-chip key schedule, a multi-block chaining register, a valid/ready handshake on both sides and a last-block flag.
- Sits between the message padder and the digest consumer.

---
 rtl/speck_mmo_hash.sv | 247 ++++++++++++++++++++++++
 tb/tb_speck_mmo_hash.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speck_mmo_hash.sv
// -----------------------------------------------------------------------------
// speck_mmo_hash
//
// Iterative Speck-2N/2N block cipher (two-word key schedule) wrapped in
// Matyas-Meyer-Oseas chaining:  H_i = E_{H_(i-1)}(M_i) XOR M_i.
// One cipher round and one key-schedule step are evaluated per clock. The
// chaining value H carries across blocks until a block flagged "last"
// completes. The digest is then presented on a valid/ready output and H is
// reloaded with IV.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   clear      reload H with IV (IDLE only; loses to a simultaneous in_valid)
//   in_valid   message block valid
//   in_ready   core can accept a block (high in IDLE)
//   in_block   message block, [2N-1:N] = x word, [N-1:0] = y word
//   in_last    block is the final block of the message
//   out_valid  digest valid (high in DONE)
//   out_ready  consumer accepts the digest
//   digest     final chaining value of the message
//   busy       high while a block is being processed or a digest is pending
// -----------------------------------------------------------------------------
module speck_mmo_hash #(
    parameter int              N      = 64,
    parameter int              ALPHA  = 8,
    parameter int              BETA   = 3,
    parameter int              ROUNDS = 32,
    parameter logic [2*N-1:0]  IV     = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_block,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] digest,
    output logic           busy
);

    // Round counter must be able to hold ROUNDS-1 (and ROUNDS after the final
    // increment, which is never used).
    localparam int RW = $clog2(ROUNDS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [N-1:0]   k_q, k_d;
    logic [N-1:0]   l_q, l_d;
    logic [2*N-1:0] msg_q, msg_d;
    logic           last_q, last_d;
    logic [RW-1:0]  rcnt_q, rcnt_d;
    logic [2*N-1:0] h_q, h_d;
    logic [2*N-1:0] digest_q, digest_d;

    // -------------------------------------------------------------------------
    // Rotations over N bits
    // -------------------------------------------------------------------------
    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
        int sm;
        sm = s % N;
        if (sm == 0) begin
            return v;
        end
        return (v >> sm) | (v << (N - sm));
    endfunction

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
        int sm;
        sm = s % N;
        if (sm == 0) begin
            return v;
        end
        return (v << sm) | (v >> (N - sm));
    endfunction

    // -------------------------------------------------------------------------
    // One Speck round plus the matching key-schedule step
    // -------------------------------------------------------------------------
    logic [N-1:0]   x_nxt;
    logic [N-1:0]   y_nxt;
    logic [N-1:0]   l_nxt;
    logic [N-1:0]   k_nxt;
    logic [N-1:0]   rnd_idx;
    logic           last_round;
    logic [2*N-1:0] mmo_out;

    // Round index zero-extended to the word width for the key schedule.
    assign rnd_idx    = N'(rcnt_q);
    assign last_round = (rcnt_q == RW'(ROUNDS - 1));

    // The round consumes k_i; the schedule produces k_(i+1) from the same k_i.
    assign x_nxt   = (ror(x_q, ALPHA) + y_q) ^ k_q;
    assign y_nxt   = rol(y_q, BETA) ^ x_nxt;
    assign l_nxt   = (k_q + ror(l_q, ALPHA)) ^ rnd_idx;
    assign k_nxt   = rol(k_q, BETA) ^ l_nxt;

    // Feed-forward of the message block closes the MMO construction.
    assign mmo_out = {x_nxt, y_nxt} ^ msg_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_round) begin
                    state_d = last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  busy     = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign digest = digest_q;

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        k_d      = k_q;
        l_d      = l_q;
        msg_d    = msg_q;
        last_d   = last_q;
        rcnt_d   = rcnt_q;
        h_d      = h_q;
        digest_d = digest_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Block acceptance wins over a simultaneous clear.
                    x_d    = in_block[2*N-1:N];
                    y_d    = in_block[N-1:0];
                    msg_d  = in_block;
                    last_d = in_last;
                    k_d    = h_q[N-1:0];
                    l_d    = h_q[2*N-1:N];
                    rcnt_d = '0;
                end else if (clear) begin
                    h_d = IV;
                end
            end
            S_RUN: begin
                x_d    = x_nxt;
                y_d    = y_nxt;
                k_d    = k_nxt;
                l_d    = l_nxt;
                rcnt_d = rcnt_q + RW'(1);
                if (last_round) begin
                    h_d = mmo_out;
                    if (last_q) begin
                        digest_d = mmo_out;
                    end
                end
            end
            S_DONE: begin
                // Digest handed off: start the next message from IV.
                if (out_ready) begin
                    h_d = IV;
                end
            end
            default: begin
                h_d = h_q;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Only the chaining value, round counter and digest
    // have defined reset values; the working words are always loaded on
    // acceptance before they are used.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt_q   <= '0;
            h_q      <= IV;
            digest_q <= '0;
        end else begin
            rcnt_q   <= rcnt_d;
            h_q      <= h_d;
            digest_q <= digest_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q    <= x_d;
        y_q    <= y_d;
        k_q    <= k_d;
        l_q    <= l_d;
        msg_q  <= msg_d;
        last_q <= last_d;
    end

endmodule

// File: tb/tb_speck_mmo_hash.sv
// -----------------------------------------------------------------------------
// tb_speck_mmo_hash
//
// Drives three instances of speck_mmo_hash (64-bit words / 32 rounds with the
// Speck128/128 key as IV, 16-bit words / 4 rounds, 16-bit words / 1 round)
// and compares their digests and handshake timing with a loop-based Speck
// plus MMO reference model.
// -----------------------------------------------------------------------------
module tb_speck_mmo_hash;

    localparam logic [127:0] KAT_IV = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KAT_M  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] KAT_D  = 128'hca3cee380c095745_0c09deba38366038;
    localparam logic [31:0]  IV1    = 32'h1234_5678;
    localparam logic [31:0]  IV2    = 32'h0000_0000;

    int rnd [3] = '{32, 4, 1};
    int nw  [3] = '{64, 16, 16};
    int al  [3] = '{8, 7, 7};
    int be  [3] = '{3, 2, 2};

    logic [127:0] ivs [3];
    logic [127:0] hm  [3];
    logic [127:0] blk [3];

    logic       clk = 1'b0;
    logic [2:0] reset;
    logic [2:0] clear;
    logic [2:0] in_valid;
    logic [2:0] in_last;
    logic [2:0] out_ready;
    wire  [2:0] in_ready;
    wire  [2:0] out_valid;
    wire  [2:0] busy;
    wire  [127:0] dg0;
    wire  [31:0]  dg1;
    wire  [31:0]  dg2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    speck_mmo_hash #(.N(64), .ALPHA(8), .BETA(3), .ROUNDS(32), .IV(KAT_IV)) u_dut0 (
        .clk(clk), .reset(reset[0]), .clear(clear[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_block(blk[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .digest(dg0), .busy(busy[0])
    );

    speck_mmo_hash #(.N(16), .ALPHA(7), .BETA(2), .ROUNDS(4), .IV(IV1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .clear(clear[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_block(blk[1][31:0]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .digest(dg1), .busy(busy[1])
    );

    speck_mmo_hash #(.N(16), .ALPHA(7), .BETA(2), .ROUNDS(1), .IV(IV2)) u_dut2 (
        .clk(clk), .reset(reset[2]), .clear(clear[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_block(blk[2][31:0]), .in_last(in_last[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .digest(dg2), .busy(busy[2])
    );

    // ---------------------------------------------------------------- model
    function automatic logic [63:0] wmask(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int s, input int n);
        logic [63:0] mk;
        mk = wmask(n);
        v  = v & mk;
        if (s % n == 0) return v;
        return ((v >> (s % n)) | (v << (n - s % n))) & mk;
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n);
        return rotr(v, n - (s % n), n);
    endfunction

    // Speck-2n/2n encryption of m under key h, then XOR with m.
    function automatic logic [127:0] mmo(input logic [127:0] h, input logic [127:0] m,
                                         input int n, input int a, input int b, input int r);
        logic [63:0] mk, x, y, k, l;
        mk = wmask(n);
        x  = 64'(m >> n) & mk;
        y  = m[63:0] & mk;
        k  = h[63:0] & mk;
        l  = 64'(h >> n) & mk;
        for (int i = 0; i < r; i++) begin
            x = ((rotr(x, a, n) + y) & mk) ^ k;
            y = rotl(y, b, n) ^ x;
            l = ((k + rotr(l, a, n)) & mk) ^ (64'(i) & mk);
            k = rotl(k, b, n) ^ l;
        end
        return (({64'd0, x} << n) | {64'd0, y}) ^ m;
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] dg(input int u);
        case (u)
            0:       return dg0;
            1:       return {96'd0, dg1};
            default: return {96'd0, dg2};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, wait for its completion and check timing and result.
    task automatic send(input int u, input logic [127:0] b, input logic lst, input logic clr);
        logic [127:0] exp;
        int           cnt;
        logic         bad;
        exp         = mmo(hm[u], b, nw[u], al[u], be[u], rnd[u]);
        in_valid[u] = 1'b1;
        blk[u]      = b;
        in_last[u]  = lst;
        clear[u]    = clr;
        cnt = 0;
        while (!in_ready[u] && cnt < 100) begin
            step();
            cnt++;
        end
        check($sformatf("u%0d_accept_ready", u), 128'(in_ready[u]), 128'd1);
        step();
        in_valid[u] = 1'b0;
        clear[u]    = 1'b0;
        blk[u]      = {$urandom, $urandom, $urandom, $urandom};
        in_last[u]  = 1'($urandom);
        cnt = 0;
        bad = 1'b0;
        while (cnt < 200) begin
            if (lst ? out_valid[u] : in_ready[u]) break;
            if (in_ready[u] || out_valid[u] || !busy[u]) bad = 1'b1;
            step();
            cnt++;
        end
        check($sformatf("u%0d_latency", u), 128'(cnt), 128'(rnd[u]));
        check($sformatf("u%0d_run_flags", u), 128'(bad), 128'd0);
        if (lst) begin
            check($sformatf("u%0d_digest", u), dg(u), exp);
            check($sformatf("u%0d_done_ready", u), 128'(in_ready[u]), 128'd0);
        end else begin
            check($sformatf("u%0d_idle_busy", u), 128'(busy[u]), 128'd0);
            hm[u] = exp;
        end
    endtask

    // Hold the digest back for 'hold' cycles, then accept it.
    task automatic drain(input int u, input int hold);
        logic [127:0] d0;
        logic         bad;
        d0  = dg(u);
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid[u] = 1'($urandom);
            clear[u]    = 1'($urandom);
            blk[u]      = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (!out_valid[u] || in_ready[u] || dg(u) !== d0) bad = 1'b1;
        end
        in_valid[u] = 1'b0;
        clear[u]    = 1'b0;
        check($sformatf("u%0d_hold_stable", u), 128'(bad), 128'd0);
        out_ready[u] = 1'b1;
        step();
        out_ready[u] = 1'b0;
        check($sformatf("u%0d_drain_valid", u), 128'(out_valid[u]), 128'd0);
        check($sformatf("u%0d_drain_ready", u), 128'(in_ready[u]), 128'd1);
        hm[u] = ivs[u];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int nb;
        ivs[0]    = KAT_IV;
        ivs[1]    = {96'd0, IV1};
        ivs[2]    = {96'd0, IV2};
        reset     = 3'b000;
        clear     = 3'b000;
        in_valid  = 3'b000;
        in_last   = 3'b000;
        out_ready = 3'b000;
        for (int u = 0; u < 3; u++) blk[u] = '0;
        repeat (3) step();
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d_rst_ready", u), 128'(in_ready[u]), 128'd1);
            check($sformatf("u%0d_rst_valid", u), 128'(out_valid[u]), 128'd0);
            check($sformatf("u%0d_rst_busy", u), 128'(busy[u]), 128'd0);
            check($sformatf("u%0d_rst_digest", u), dg(u), 128'd0);
            hm[u] = ivs[u];
        end
        reset = 3'b111;
        step();

        // Single-block known answer
        send(0, KAT_M, 1'b1, 1'b0);
        check("kat_single", dg0, KAT_D);
        drain(0, 0);

        // Two-block chaining with backpressure on the digest
        send(0, KAT_M, 1'b0, 1'b0);
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        drain(0, 10);
        send(0, KAT_M, 1'b1, 1'b0);
        check("kat_after_chain", dg0, KAT_D);
        drain(0, 1);

        // Reset in the middle of a run
        in_valid[0] = 1'b1;
        blk[0]      = KAT_M;
        in_last[0]  = 1'b1;
        check("midrst_pre_ready", 128'(in_ready[0]), 128'd1);
        step();
        in_valid[0] = 1'b0;
        repeat (15) step();
        reset[0] = 1'b0;
        step();
        reset[0] = 1'b1;
        check("midrst_ready", 128'(in_ready[0]), 128'd1);
        check("midrst_valid", 128'(out_valid[0]), 128'd0);
        check("midrst_busy", 128'(busy[0]), 128'd0);
        check("midrst_digest", dg0, 128'd0);
        hm[0] = ivs[0];
        send(0, KAT_M, 1'b1, 1'b0);
        check("kat_after_reset", dg0, KAT_D);
        drain(0, 2);

        // Clear in IDLE between blocks restores IV
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        hm[0] = ivs[0];
        send(0, KAT_M, 1'b1, 1'b0);
        check("kat_after_clear", dg0, KAT_D);
        drain(0, 0);

        // Clear together with a block is ignored
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1);
        drain(0, 3);

        // Small-word instances with random messages
        for (int u = 1; u < 3; u++) begin
            for (int m = 0; m < 8; m++) begin
                nb = 1 + int'($urandom % 3);
                for (int b = 0; b < nb; b++) begin
                    send(u, {96'd0, 32'($urandom)}, (b == nb - 1), ($urandom % 4 == 0));
                    if (b != nb - 1 && ($urandom % 4 == 0)) begin
                        clear[u] = 1'b1;
                        step();
                        clear[u] = 1'b0;
                        hm[u] = ivs[u];
                    end
                end
                drain(u, int'($urandom % 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
